// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2
  } owner_e;

  // Width of the wait-state down-counter; WAIT_CYCLES must fit in it.
  localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/dmem_wait_timer.sv
// Loadable down-counter; last_o is high whenever the count sits at zero.
module dmem_wait_timer
  import dmem_arb_pkg::*;
#(
  parameter int unsigned W = WAIT_CNT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage and a debug/loader port,
// one access at a time through a fixed wait-state window.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic              cpu_done_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  output logic              dbg_ready_o,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_done_q, cpu_done_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic idle, starved, grant_cpu, grant_dbg, timer_load, timer_last;

  // Debug wins only when the CPU is absent or the debug port has been starved long enough.
  assign idle      = (state_q == IDLE);
  assign starved   = (starve_q == SW'(STARVE_MAX));
  assign grant_cpu = idle & cpu_req_i & ~(dbg_req_i & starved);
  assign grant_dbg = idle & dbg_req_i & (starved | ~cpu_req_i);

  assign dbg_ready_o = idle & (~cpu_req_i | starved);
  assign cpu_stall_o = cpu_req_i & ~cpu_done_q;

  dmem_wait_timer #(.W(WAIT_CNT_W)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (timer_load),
    .load_val_i (WAIT_CNT_W'(WAIT_CYCLES)),
    .last_o     (timer_last)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    cpu_done_d   = 1'b0;
    cpu_rdata_d  = '0;
    dbg_rvalid_d = 1'b0;
    dbg_rdata_d  = '0;
    timer_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_cpu || grant_dbg) begin
          state_d     = BUSY;
          owner_d     = grant_dbg ? DBG : CPU;
          we_d        = grant_dbg ? dbg_we_i : cpu_we_i;
          mem_addr_d  = grant_dbg ? dbg_addr_i : cpu_addr_i;
          mem_wdata_d = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          timer_load  = 1'b1;
          if (grant_dbg) begin
            starve_d = '0;
          end else if (dbg_req_i && !starved) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      BUSY: begin
        // Read data is sampled on the final wait-state edge; writes return zero.
        if (timer_last) begin
          state_d      = DONE;
          cpu_done_d   = (owner_q == CPU);
          dbg_rvalid_d = (owner_q == DBG);
          if (owner_q == CPU && !we_q) cpu_rdata_d = mem_rdata_i;
          if (owner_q == DBG && !we_q) dbg_rdata_d = mem_rdata_i;
        end
      end
      DONE: begin
        state_d = IDLE;
        owner_d = NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= NONE;
      starve_q     <= '0;
      we_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      we_q         <= we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_done_q   <= cpu_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign cpu_done_o   = cpu_done_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_rdata_o  = dbg_rdata_q;

endmodule
